// File: rtl/bus_pkg.sv
// Shared bus definitions used by both the burst initiator and the burst responder:
// FSM state encodings and the rule that converts a burst_size field to a word count.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FETCH = 3'd1,
        RD_DATA  = 3'd2,
        RD_END   = 3'd3,
        WR_DATA  = 3'd4,
        ERR      = 3'd5
    } bus_state_e;

    // Word counter is one bit wider than burst_size so that a 256-word burst fits.
    localparam int BURST_CNT_W = 9;

    // burst_size encodes (words - 1).
    function automatic logic [BURST_CNT_W-1:0] burst_words(input logic [7:0] burst_size);
        return {1'b0, burst_size} + 9'd1;
    endfunction

    // An all-zero byte-enable field means "whole word".
    function automatic logic [3:0] effective_be(input logic [3:0] be);
        return (be == 4'b0000) ? 4'b1111 : be;
    endfunction

endpackage

// File: rtl/responder_ram.sv
// Single-port word RAM for the burst responder: synchronous read with one cycle
// of latency and per-byte write enables. A write cycle does not update the read port.
module responder_ram #(
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic [3:0]           we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_BITS)-1];
    logic [31:0] rdata_q;

    // Byte-masked write, or registered read when no byte is enabled.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (we_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_burst_responder.sv
// Burst bus responder backed by a local RAM window. Reads stream one word per
// cycle after a one-cycle fetch; writes accept one word per cycle while not busy.
// Addresses outside the window or not word aligned produce a one-cycle error.
module bus_burst_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          ADDR_BITS    = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic        read_n_write_in,
    input  logic        data_valid_in,
    input  logic        end_transaction_in,
    input  logic [31:0] address_data_in,
    input  logic [7:0]  burst_size_in,
    input  logic [3:0]  byte_enables_in,
    input  logic        stall_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam logic [32:0]          WINDOW_BYTES = 33'd1 << (ADDR_BITS + 2);
    localparam logic [ADDR_BITS-1:0] IDX_ONE      = 1;

    bus_state_e             state_q;
    logic [ADDR_BITS-1:0]   idx_q;      // next RAM word to read or write
    logic [BURST_CNT_W-1:0] cnt_q;      // words transferred so far
    logic [BURST_CNT_W-1:0] n_q;        // words in this burst
    logic [3:0]             be_q;       // effective byte enables for writes

    logic [31:0]            offset_d;
    logic                   addr_ok_d;
    logic [ADDR_BITS-1:0]   start_idx_d;
    logic [BURST_CNT_W-1:0] cnt_inc_d;
    logic                   wr_accept;
    logic                   rd_advance;
    logic                   ram_en;
    logic [3:0]             ram_we;
    logic [31:0]            ram_rdata;

    // Start-address decode and RAM port control.
    always_comb begin
        offset_d    = address_data_in - BASE_ADDRESS;
        addr_ok_d   = (address_data_in[1:0] == 2'b00) &&
                      (address_data_in >= BASE_ADDRESS) &&
                      ({1'b0, offset_d} < WINDOW_BYTES);
        start_idx_d = offset_d[ADDR_BITS+1:2];
        cnt_inc_d   = cnt_q + 9'd1;
        // Words past the burst length are dropped; busy (stall) blocks acceptance.
        wr_accept   = (state_q == WR_DATA) && data_valid_in && !stall_in && (cnt_q != n_q);
        // A stalled read keeps the RAM output register, and so the current word, frozen.
        rd_advance  = (state_q == RD_FETCH) || ((state_q == RD_DATA) && !stall_in);
        ram_en      = wr_accept || rd_advance;
        ram_we      = wr_accept ? be_q : 4'b0000;
    end

    // Transaction FSM with burst counters; indices wrap naturally at the window end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (begin_transaction_in) begin
                        if (addr_ok_d) begin
                            idx_q   <= start_idx_d;
                            cnt_q   <= '0;
                            n_q     <= burst_words(burst_size_in);
                            be_q    <= effective_be(byte_enables_in);
                            state_q <= read_n_write_in ? RD_FETCH : WR_DATA;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                RD_FETCH: begin
                    if (end_transaction_in) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (end_transaction_in) begin
                        state_q <= IDLE;
                    end else if (!stall_in) begin
                        cnt_q <= cnt_inc_d;
                        idx_q <= idx_q + IDX_ONE;
                        if (cnt_inc_d == n_q) begin
                            state_q <= RD_END;
                        end
                    end
                end
                RD_END: state_q <= IDLE;
                WR_DATA: begin
                    if (wr_accept) begin
                        cnt_q <= cnt_inc_d;
                        idx_q <= idx_q + IDX_ONE;
                    end
                    if (end_transaction_in) begin
                        state_q <= IDLE;
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    responder_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk_i   (clock),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (idx_q),
        .wdata_i (address_data_in),
        .rdata_o (ram_rdata)
    );

    // Outputs decode the registered state; the data bus is forced to zero when not valid.
    assign data_valid_out      = (state_q == RD_DATA) && !stall_in;
    assign address_data_out    = data_valid_out ? ram_rdata : 32'h0;
    assign end_transaction_out = (state_q == RD_END);
    assign error_out           = (state_q == ERR);
    assign busy_out            = (state_q == WR_DATA) && stall_in;

endmodule
